// File: rtl/conditional_subtract_select.sv
// conditional_subtract_select
// Final reduction stage behind a word-serial subtractor. It collects the
// operand stream (A, B) and the difference stream (D = A - B). It decides
// serially whether A >= B, then replays D when A >= B and A otherwise,
// LSW first.
module conditional_subtract_select #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 2048
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [REGISTER_SIZE-1:0] a_in,
  input  logic [REGISTER_SIZE-1:0] b_in,
  input  logic                     valid_in,
  input  logic [REGISTER_SIZE-1:0] diff_in,
  input  logic                     diff_valid_in,
  input  logic                     diff_final_in,
  output logic                     ready_out,
  output logic [REGISTER_SIZE-1:0] data_out,
  output logic                     valid_out,
  output logic                     final_out,
  output logic                     ge_out
);

  localparam int NUM_WORDS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int CW        = $clog2(NUM_WORDS) + 1;
  localparam int AW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_WORDS);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_WORDS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    ST_COLLECT,
    ST_OUTPUT
  } state_e;

  state_e                   state_q;
  logic [CW-1:0]            a_cnt_q, a_cnt_d;
  logic [CW-1:0]            d_cnt_q, d_cnt_d;
  logic [CW-1:0]            r_cnt_q;
  logic                     ge_q, ge_d;
  logic                     a_take, d_take, collect_done;

  logic                     rd_valid_q;
  logic                     rd_last_q;
  logic [REGISTER_SIZE-1:0] a_rdata_q;
  logic [REGISTER_SIZE-1:0] d_rdata_q;

  logic [REGISTER_SIZE-1:0] data_q;
  logic                     valid_q;
  logic                     final_q;
  logic                     ge_out_q;

  logic [REGISTER_SIZE-1:0] a_mem [NUM_WORDS];
  logic [REGISTER_SIZE-1:0] d_mem [NUM_WORDS];

  // The end-of-number marker is redundant because the word counters decide completion.
  logic unused_diff_final;
  assign unused_diff_final = diff_final_in;

  // Accept words only while collecting and while a stream is not yet full.
  // The compare flag follows the latest unequal word, so the MSW decides.
  always_comb begin
    a_take       = (state_q == ST_COLLECT) && valid_in && (a_cnt_q != CNT_FULL);
    d_take       = (state_q == ST_COLLECT) && diff_valid_in && (d_cnt_q != CNT_FULL);
    a_cnt_d      = a_take ? (a_cnt_q + CNT_ONE) : a_cnt_q;
    d_cnt_d      = d_take ? (d_cnt_q + CNT_ONE) : d_cnt_q;
    ge_d         = ge_q;
    if (a_take) begin
      if (a_in > b_in) begin
        ge_d = 1'b1;
      end else if (a_in < b_in) begin
        ge_d = 1'b0;
      end
    end
    collect_done = (a_cnt_d == CNT_FULL) && (d_cnt_d == CNT_FULL);
  end

  // Word buffers have a write port and one registered read port, so they can map to block RAM.
  always_ff @(posedge clk_in) begin
    if (a_take) begin
      a_mem[a_cnt_q[AW-1:0]] <= a_in;
    end
    if (d_take) begin
      d_mem[d_cnt_q[AW-1:0]] <= diff_in;
    end
    a_rdata_q <= a_mem[r_cnt_q[AW-1:0]];
    d_rdata_q <= d_mem[r_cnt_q[AW-1:0]];
  end

  // Collect/replay controller. It issues one read per cycle, then registers the selected word one cycle later.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_COLLECT;
      a_cnt_q    <= '0;
      d_cnt_q    <= '0;
      r_cnt_q    <= '0;
      ge_q       <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      final_q    <= 1'b0;
      ge_out_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          a_cnt_q    <= a_cnt_d;
          d_cnt_q    <= d_cnt_d;
          ge_q       <= ge_d;
          r_cnt_q    <= '0;
          rd_valid_q <= 1'b0;
          rd_last_q  <= 1'b0;
          valid_q    <= 1'b0;
          final_q    <= 1'b0;
          if (collect_done) begin
            state_q <= ST_OUTPUT;
          end
        end
        ST_OUTPUT: begin
          if (r_cnt_q != CNT_FULL) begin
            r_cnt_q    <= r_cnt_q + CNT_ONE;
            rd_valid_q <= 1'b1;
            rd_last_q  <= (r_cnt_q == CNT_LAST);
          end else begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
          end
          valid_q  <= rd_valid_q;
          final_q  <= rd_last_q;
          ge_out_q <= ge_q;
          if (rd_valid_q) begin
            data_q <= ge_q ? d_rdata_q : a_rdata_q;
          end
          if (final_q) begin
            state_q    <= ST_COLLECT;
            a_cnt_q    <= '0;
            d_cnt_q    <= '0;
            r_cnt_q    <= '0;
            ge_q       <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_COLLECT;
        end
      endcase
    end
  end

  assign ready_out = (state_q == ST_COLLECT);
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign final_out = final_q;
  assign ge_out    = ge_out_q;

endmodule

// File: tb/tb_conditional_subtract_select.sv
// Testbench for conditional_subtract_select. A 4-word instance runs directed and
// random numbers, and a default 64-word instance runs random numbers. Expected
// words are queued when stimulus is issued, and monitors compare them against the outputs.
module tb_conditional_subtract_select;

  localparam int NW  = 4;
  localparam int NWB = 64;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        ge;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN, vIn, dvIn, dfIn;
  logic [31:0] aIn, bIn, dIn;
  logic        readyOut, validOut, finalOut, geOut;
  logic [31:0] dataOut;

  logic        rstBigN, vBig, dvBig, dfBig;
  logic [31:0] aBig, bBig, dBig;
  logic        readyBig, validBig, finalBig, geBig;
  logic [31:0] dataBig;

  int          compared   = 0;
  int          mismatched = 0;
  bit          monEnable  = 1'b1;
  bit          bigDone    = 1'b0;

  exp_t        expQ[$];
  exp_t        expBigQ[$];
  exp_t        monE, monBigE;
  logic [31:0] aQ[$], bQ[$], dQ[$];

  conditional_subtract_select #(.REGISTER_SIZE(32), .BITS_IN_NUM(128)) dut (
    .clk_in(clk), .rst_in(rstN), .a_in(aIn), .b_in(bIn), .valid_in(vIn),
    .diff_in(dIn), .diff_valid_in(dvIn), .diff_final_in(dfIn),
    .ready_out(readyOut), .data_out(dataOut), .valid_out(validOut),
    .final_out(finalOut), .ge_out(geOut)
  );

  conditional_subtract_select dutBig (
    .clk_in(clk), .rst_in(rstBigN), .a_in(aBig), .b_in(bBig), .valid_in(vBig),
    .diff_in(dBig), .diff_valid_in(dvBig), .diff_final_in(dfBig),
    .ready_out(readyBig), .data_out(dataBig), .valid_out(validBig),
    .final_out(finalBig), .ge_out(geBig)
  );

  // Single comparison point: every check steps the counters printed in the summary
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference: the most significant unequal word decides; equal numbers count as A >= B
  function automatic bit refGe(input logic [31:0] a[$], input logic [31:0] b[$]);
    for (int i = a.size() - 1; i >= 0; i--) begin
      if (a[i] != b[i]) return a[i] > b[i];
    end
    return 1'b1;
  endfunction

  // Reference: multiword A - B with borrow, modulo 2^bits
  function automatic void computeDiff(input logic [31:0] a[$], input logic [31:0] b[$], output logic [31:0] d[$]);
    logic [32:0] t;
    logic        borrow;
    borrow = 1'b0;
    d = {};
    for (int i = 0; i < a.size(); i++) begin
      t = {1'b0, a[i]} - {1'b0, b[i]} - {32'b0, borrow};
      d.push_back(t[31:0]);
      borrow = t[32];
    end
  endfunction

  // Reference: the selected number streamed LSW first, with the last-word flag and comparison result
  function automatic void buildExpected(input logic [31:0] a[$], input logic [31:0] b[$], input logic [31:0] d[$], input int n, output exp_t out[$]);
    exp_t e;
    bit   ge;
    ge = refGe(a, b);
    out = {};
    for (int i = 0; i < n; i++) begin
      e.data = ge ? d[i] : a[i];
      e.last = (i == n - 1);
      e.ge   = ge;
      out.push_back(e);
    end
  endfunction

  // Drive one small number from aQ/bQ/dQ with independent start offsets. The task returns one time step after edge k.
  task automatic applyStimulus(input int aStart, input int dStart, input int nD, input bit queueExpected);
    int   guard;
    int   total;
    exp_t tmp[$];
    guard = 0;
    while (readyOut !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      compared++; mismatched++;
      $display("[TB] FAIL ready wait: got timeout, expected ready_out=1");
    end
    if (queueExpected) begin
      buildExpected(aQ, bQ, dQ, NW, tmp);
      foreach (tmp[i]) expQ.push_back(tmp[i]);
    end
    total = ((aStart + NW) > (dStart + nD)) ? (aStart + NW) : (dStart + nD);
    for (int t = 0; t < total; t++) begin
      vIn  = (t >= aStart) && (t < aStart + NW);
      dvIn = (t >= dStart) && (t < dStart + nD);
      aIn  = vIn ? aQ[t - aStart] : $urandom;
      bIn  = vIn ? bQ[t - aStart] : $urandom;
      dIn  = dvIn ? dQ[t - dStart] : $urandom;
      dfIn = dvIn && (t - dStart == NW - 1);
      @(posedge clk); #1;
    end
    vIn = 1'b0; dvIn = 1'b0; dfIn = 1'b0;
  endtask

  // Monitor for the 4-word instance: pop one expectation per valid output word
  always @(negedge clk) begin
    if (monEnable && rstN && validOut) begin
      if (expQ.size() == 0) begin
        compared++; mismatched++;
        $display("[TB] FAIL small unexpected word: got %0h, expected no output", dataOut);
      end else begin
        monE = expQ.pop_front();
        checkOutput("small data", dataOut, monE.data);
        checkOutput("small final", {31'b0, finalOut}, {31'b0, monE.last});
        checkOutput("small ge", {31'b0, geOut}, {31'b0, monE.ge});
      end
    end
  end

  // Monitor for the 64-word instance
  always @(negedge clk) begin
    if (rstBigN && validBig) begin
      if (expBigQ.size() == 0) begin
        compared++; mismatched++;
        $display("[TB] FAIL big unexpected word: got %0h, expected no output", dataBig);
      end else begin
        monBigE = expBigQ.pop_front();
        checkOutput("big data", dataBig, monBigE.data);
        checkOutput("big final", {31'b0, finalBig}, {31'b0, monBigE.last});
        checkOutput("big ge", {31'b0, geBig}, {31'b0, monBigE.ge});
      end
    end
  end

  // Random 64-word numbers on the default-parameter instance: alternate A >= B and A < B
  initial begin
    logic [31:0] aB[$], bB[$], dB[$], sw[$];
    exp_t        tmp[$];
    int          guard;
    rstBigN = 1'b0; vBig = 1'b0; dvBig = 1'b0; dfBig = 1'b0;
    aBig = '0; bBig = '0; dBig = '0;
    #23 rstBigN = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 4; n++) begin
      aB = {}; bB = {};
      for (int i = 0; i < NWB; i++) begin
        bB.push_back($urandom);
        aB.push_back(($urandom_range(0, 2) == 0) ? bB[i] : $urandom);
      end
      if (refGe(aB, bB) != ((n % 2) == 0)) begin
        sw = aB; aB = bB; bB = sw;
      end
      if (n == 2) aB = bB;
      computeDiff(aB, bB, dB);
      guard = 0;
      while (readyBig !== 1'b1 && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 200) begin
        compared++; mismatched++;
        $display("[TB] FAIL big ready wait: got timeout, expected ready_out=1");
      end
      buildExpected(aB, bB, dB, NWB, tmp);
      foreach (tmp[i]) expBigQ.push_back(tmp[i]);
      for (int t = 0; t < NWB + 2; t++) begin
        vBig  = (t < NWB);
        dvBig = (t >= 2);
        aBig  = vBig ? aB[t] : 32'h0;
        bBig  = vBig ? bB[t] : 32'h0;
        dBig  = dvBig ? dB[t - 2] : 32'h0;
        dfBig = dvBig && (t - 2 == NWB - 1);
        @(posedge clk); #1;
      end
      vBig = 1'b0; dvBig = 1'b0; dfBig = 1'b0;
    end
    bigDone = 1'b1;
  end

  // Global time limit so the bench always terminates
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios, reset cases and random numbers on the 4-word instance
  initial begin
    int firstValid, validCnt, finalAt, readyLow, guard, sel, aS, dS;

    rstN = 1'b0; vIn = 1'b0; dvIn = 1'b0; dfIn = 1'b0;
    aIn = '0; bIn = '0; dIn = '0;
    #3;
    checkOutput("reset ready", {31'b0, readyOut}, 32'd1);
    checkOutput("reset valid", {31'b0, validOut}, 32'd0);
    checkOutput("reset final", {31'b0, finalOut}, 32'd0);
    checkOutput("reset ge", {31'b0, geOut}, 32'd0);
    checkOutput("reset data", dataOut, 32'd0);
    #20 rstN = 1'b1;
    @(posedge clk); #1;

    $display("[TB] A > B with D three cycles late, plus latency checks");
    aQ = {32'd5, 32'd0, 32'd0, 32'd0};
    bQ = {32'd3, 32'd0, 32'd0, 32'd0};
    dQ = {32'd2, 32'd0, 32'd0, 32'd0};
    applyStimulus(0, 3, NW, 1'b1);
    checkOutput("ready low after edge k", {31'b0, readyOut}, 32'd0);
    readyLow = 1; firstValid = -1; validCnt = 0; finalAt = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (validOut) begin
        if (firstValid < 0) firstValid = c;
        validCnt++;
      end
      if (finalOut) finalAt = c;
      if (!readyOut) readyLow++;
      else break;
    end
    checkOutput("first valid edge", firstValid, 32'd2);
    checkOutput("valid cycle count", validCnt, 32'd4);
    checkOutput("final edge", finalAt, 32'd5);
    checkOutput("ready low cycles", readyLow, 32'd6);

    $display("[TB] A < B decided at MSW");
    aQ = {32'd0, 32'd0, 32'd0, 32'd1};
    bQ = {32'd0, 32'd0, 32'd0, 32'd2};
    dQ = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(0, 1, NW, 1'b1);

    $display("[TB] equal operands in three stream orderings");
    aQ = {32'd7, 32'd7, 32'd7, 32'd7};
    bQ = {32'd7, 32'd7, 32'd7, 32'd7};
    dQ = {32'd0, 32'd0, 32'd0, 32'd0};
    applyStimulus(0, 2, NW, 1'b1);
    applyStimulus(4, 0, NW, 1'b1);
    applyStimulus(0, 0, NW, 1'b1);

    $display("[TB] inputs during OUTPUT are ignored");
    aQ = {32'h10, 32'h0, 32'h0, 32'h9};
    bQ = {32'h01, 32'h0, 32'h0, 32'h8};
    computeDiff(aQ, bQ, dQ);
    applyStimulus(0, 0, NW, 1'b1);
    for (int c = 0; c < 4; c++) begin
      vIn = 1'b1; aIn = 32'h0; bIn = 32'hffffffff;
      dvIn = 1'b1; dIn = 32'hdeadbeef;
      @(posedge clk); #1;
    end
    vIn = 1'b0; dvIn = 1'b0;
    aQ = {32'h3, 32'h4, 32'h5, 32'h6};
    bQ = {32'h1, 32'h1, 32'h1, 32'h1};
    computeDiff(aQ, bQ, dQ);
    applyStimulus(0, 1, NW, 1'b1);

    $display("[TB] fifth D word during COLLECT is dropped");
    aQ = {32'h20, 32'h0, 32'h0, 32'h1};
    bQ = {32'h10, 32'h0, 32'h0, 32'h0};
    computeDiff(aQ, bQ, dQ);
    dQ.push_back(32'hbadc0de5);
    applyStimulus(2, 0, NW + 1, 1'b1);

    $display("[TB] reset after two operand words");
    guard = 0;
    while (readyOut !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    for (int t = 0; t < 2; t++) begin
      vIn = 1'b1; aIn = 32'hffffffff; bIn = 32'h0;
      dvIn = 1'b1; dIn = 32'h12345678;
      @(posedge clk); #1;
    end
    vIn = 1'b0; dvIn = 1'b0;
    #1 rstN = 1'b0;
    #1;
    checkOutput("async reset ready", {31'b0, readyOut}, 32'd1);
    checkOutput("async reset valid", {31'b0, validOut}, 32'd0);
    checkOutput("async reset data", dataOut, 32'd0);
    checkOutput("async reset ge", {31'b0, geOut}, 32'd0);
    rstN = 1'b1;
    @(posedge clk); #1;
    aQ = {32'h1, 32'h2, 32'h3, 32'h4};
    bQ = {32'h1, 32'h2, 32'h3, 32'h5};
    dQ = {32'haaaa0000, 32'hbbbb0000, 32'hcccc0000, 32'hdddd0000};
    applyStimulus(0, 0, NW, 1'b1);

    $display("[TB] reset in the middle of the output burst");
    guard = 0;
    while (expQ.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    monEnable = 1'b0;
    aQ = {32'h9, 32'h9, 32'h9, 32'h9};
    bQ = {32'h1, 32'h1, 32'h1, 32'h1};
    computeDiff(aQ, bQ, dQ);
    applyStimulus(0, 0, NW, 1'b0);
    guard = 0;
    while (validOut !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("valid seen before reset", {31'b0, validOut}, 32'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("mid-output reset valid", {31'b0, validOut}, 32'd0);
    checkOutput("mid-output reset ready", {31'b0, readyOut}, 32'd1);
    checkOutput("mid-output reset final", {31'b0, finalOut}, 32'd0);
    rstN = 1'b1;
    @(posedge clk); #1;
    monEnable = 1'b1;

    $display("[TB] random 4-word numbers");
    for (int n = 0; n < 20; n++) begin
      aQ = {}; bQ = {};
      for (int i = 0; i < NW; i++) begin
        bQ.push_back($urandom);
        sel = $urandom_range(0, 2);
        if (sel == 0) aQ.push_back(bQ[i]);
        else if (sel == 1) aQ.push_back(bQ[i] + 32'd1);
        else aQ.push_back($urandom);
      end
      computeDiff(aQ, bQ, dQ);
      aS = $urandom_range(0, 3);
      dS = $urandom_range(0, 3);
      applyStimulus(aS, dS, NW, 1'b1);
    end

    guard = 0;
    while (!bigDone && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bigDone) begin
      compared++; mismatched++;
      $display("[TB] FAIL big stimulus: got timeout, expected completion");
    end
    guard = 0;
    while ((expQ.size() != 0 || expBigQ.size() != 0) && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("small queue drained", expQ.size(), 32'd0);
    checkOutput("big queue drained", expBigQ.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
